// File: rtl/sent_pkg.sv
// Shared constants, CRC parameters and FSM state type for the SENT transmit scheduler.
// CRC parameters are used only when SENT_SERIAL_CRC_EN is defined.
package sent_pkg;

  localparam int SHORT_FRAMES = 16;
  localparam int ENH_FRAMES   = 18;

  // Polynomials are stored without their leading x^n term.
  localparam logic [3:0] CRC4_POLY = 4'b1101;
  localparam logic [3:0] CRC4_SEED = 4'b0101;
  localparam logic [5:0] CRC6_POLY = 6'b011001;
  localparam logic [5:0] CRC6_SEED = 6'b010101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } sent_state_e;

endpackage

// File: rtl/sent_serial_crc.sv
// Combinational slow-channel CRC: CRC4 over the short message, CRC6 over the enhanced message.
// Instantiated by the scheduler only when SENT_SERIAL_CRC_EN is defined.
module sent_serial_crc
  import sent_pkg::*;
(
  input  logic        channel_format,
  input  logic        config_bit,
  input  logic [7:0]  id,
  input  logic [15:0] data,
  output logic [5:0]  crc
);

  always_comb begin
    logic [11:0] s_bits;
    logic [11:0] e_bit3;
    logic [23:0] e_bits;
    logic [3:0]  c4;
    logic [5:0]  c6;
    logic        fb;
    s_bits = {id[3:0], data[7:0]};
    // Enhanced message bits: {bit3, bit2} per frame for frames 6..17, MSB first.
    e_bit3 = {1'b0, config_bit, (config_bit ? data[15:12] : id[7:4]), 1'b0, id[3:0], 1'b0};
    e_bits = '0;
    for (int i = 0; i < 12; i++) begin
      e_bits[23 - 2*i] = e_bit3[11 - i];
      e_bits[22 - 2*i] = data[11 - i];
    end
    c4 = CRC4_SEED;
    for (int i = 11; i >= 0; i--) begin
      fb = c4[3] ^ s_bits[i];
      c4 = {c4[2:0], 1'b0};
      if (fb) c4 = c4 ^ CRC4_POLY;
    end
    c6 = CRC6_SEED;
    for (int i = 23; i >= 0; i--) begin
      fb = c6[5] ^ e_bits[i];
      c6 = {c6[4:0], 1'b0};
      if (fb) c6 = c6 ^ CRC6_POLY;
    end
    crc = channel_format ? c6 : {2'b00, c4};
  end

endmodule

// File: rtl/sent_tx_scheduler.sv
// SENT frame scheduler: pops fast-channel words, builds slow-channel status bits, paces frames.
// Define SENT_SERIAL_CRC_EN to transmit real serial CRCs; otherwise CRC positions carry 0.
module sent_tx_scheduler
  import sent_pkg::*;
#(
  parameter int DATAWIDTH = 12
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 enable,
  input  logic                 channel_format,
  input  logic                 config_bit,
  input  logic [7:0]           id,
  input  logic [15:0]          data_bit_field,
  input  logic                 fifo_empty,
  input  logic [DATAWIDTH-1:0] fifo_rdata,
  output logic                 fifo_rd,
  output logic                 frame_valid,
  output logic [DATAWIDTH-1:0] frame_data,
  output logic [3:0]           frame_status,
  input  logic                 frame_ready,
  output logic                 msg_done,
  output logic                 underflow
);

  sent_state_e          state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [7:0]           id_q, id_d;
  logic [15:0]          dbf_q, dbf_d;
  logic                 fmt_q, fmt_d;
  logic                 cfg_q, cfg_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [3:0]           status_q, status_d;
  logic                 msg_done_q, msg_done_d;
  logic [5:0]           crc_w;
  logic                 b3, b2, last;

`ifdef SENT_SERIAL_CRC_EN
  sent_serial_crc u_crc (
    .channel_format (fmt_q),
    .config_bit     (cfg_q),
    .id             (id_q),
    .data           (dbf_q),
    .crc            (crc_w)
  );
`else
  assign crc_w = '0;
`endif

  // Serial bits for the frame currently being loaded.
  always_comb begin
    b3 = 1'b0;
    b2 = 1'b0;
    if (!fmt_q) begin
      b3 = (idx_q == 5'd0);
      if (idx_q < 5'd4)       b2 = id_q[3'(5'd3 - idx_q)];
      else if (idx_q < 5'd12) b2 = dbf_q[4'(5'd11 - idx_q)];
      else                    b2 = crc_w[3'(5'd15 - idx_q)];
    end else if (idx_q < 5'd6) begin
      b3 = 1'b1;
      b2 = crc_w[3'(5'd5 - idx_q)];
    end else begin
      b2 = dbf_q[4'(5'd17 - idx_q)];
      if (idx_q == 5'd7)
        b3 = cfg_q;
      else if (idx_q >= 5'd8 && idx_q <= 5'd11)
        b3 = cfg_q ? dbf_q[4'(5'd23 - idx_q)] : id_q[3'(5'd15 - idx_q)];
      else if (idx_q >= 5'd13 && idx_q <= 5'd16)
        b3 = id_q[3'(5'd16 - idx_q)];
    end
  end

  assign last = (idx_q == (fmt_q ? 5'(ENH_FRAMES - 1) : 5'(SHORT_FRAMES - 1)));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    id_d       = id_q;
    dbf_d      = dbf_q;
    fmt_d      = fmt_q;
    cfg_d      = cfg_q;
    data_d     = data_q;
    status_d   = status_q;
    msg_done_d = 1'b0;
    fifo_rd    = 1'b0;
    underflow  = 1'b0;
    frame_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          id_d    = id;
          dbf_d   = data_bit_field;
          fmt_d   = channel_format;
          cfg_d   = config_bit;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          data_d  = fifo_rdata;
        end else begin
          underflow = 1'b1;
        end
        status_d = {b3, b2, 2'b00};
        state_d  = SEND;
      end
      SEND: begin
        frame_valid = 1'b1;
        if (frame_ready) begin
          if (!last) begin
            idx_d   = idx_q + 5'd1;
            state_d = LOAD;
          end else begin
            msg_done_d = 1'b1;
            // enable is only looked at here, so a drop mid-message lets it finish.
            if (enable) begin
              id_d    = id;
              dbf_d   = data_bit_field;
              fmt_d   = channel_format;
              cfg_d   = config_bit;
              idx_d   = '0;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      id_q       <= '0;
      dbf_q      <= '0;
      fmt_q      <= 1'b0;
      cfg_q      <= 1'b0;
      data_q     <= '0;
      status_q   <= '0;
      msg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      id_q       <= id_d;
      dbf_q      <= dbf_d;
      fmt_q      <= fmt_d;
      cfg_q      <= cfg_d;
      data_q     <= data_d;
      status_q   <= status_d;
      msg_done_q <= msg_done_d;
    end
  end

  assign frame_data   = data_q;
  assign frame_status = status_q;
  assign msg_done     = msg_done_q;

endmodule

// File: doc/sent_tx_scheduler.md
# sent_tx_scheduler

SENT transmit frame scheduler in the APB clock domain, sitting between the APB-written fast-channel data FIFO and the SENT frame transmitter. Each fast-channel frame takes one 12-bit data word from the FIFO and one status nibble. The block builds the slow-channel serial message (short or enhanced) into bits 3:2 of the status nibble, two bits per frame. It paces frames against the transmitter's ready handshake and reports message completion and FIFO underflow.

## Interface
- DATAWIDTH, 12, fast-channel data bits per frame (3 nibbles)
- PCLK  in  1  clock, rising edge
- PRESETn  in  1  asynchronous active-low reset
- enable  in  1  level; start/continue scheduling
- channel_format  in  1  0: short serial, 1: enhanced serial
- config_bit  in  1  enhanced only; 0: 8-bit id/12-bit data, 1: 4-bit id/16-bit data
- id  in  8  serial message id, sampled at message start
- data_bit_field  in  16  serial message data, sampled at message start
- fifo_empty  in  1  FIFO has no word
- fifo_rdata  in  DATAWIDTH  first-word-fall-through head of FIFO
- fifo_rd  out  1  one-cycle pop strobe
- frame_valid  out  1  frame offered to transmitter
- frame_data  out  DATAWIDTH  fast-channel data of offered frame
- frame_status  out  4  status nibble; [3:2] serial bits, [1:0] = 0
- frame_ready  in  1  transmitter accepts frame when high with frame_valid
- msg_done  out  1  one-cycle pulse when last frame of a serial message is accepted
- underflow  out  1  one-cycle pulse when a frame is loaded with the FIFO empty

## Operation
- States: IDLE, LOAD, SEND.
- IDLE → LOAD when enable=1. Sample id, data_bit_field, channel_format and config_bit into message registers. Set frame_idx=0.
- LOAD, one cycle:
  - If !fifo_empty: fifo_rd=1 and latch fifo_rdata.
  - Otherwise repeat the last sent data word (0 after reset) and pulse underflow.
  - Compute status from frame_idx. Go to SEND.
- SEND: frame_valid=1, with frame_data/frame_status held stable until frame_ready=1 on a rising edge. On acceptance:
  - If this is not the last frame, increment frame_idx and go to LOAD.
  - If it is the last frame, pulse msg_done. Then go to LOAD with a new sample and frame_idx=0 if enable=1, else go to IDLE.
- enable=0 mid-message does not abort; the message completes. enable is checked only at message boundaries.
- Short serial, 16 frames:
  - bit3 = 1 on frame 0, 0 on frames 1–15.
  - bit2 stream, MSB first: id[3:0] (frames 0–3), data[7:0] (frames 4–11), CRC4 (frames 12–15).
- Enhanced serial, 18 frames:
  - bit3: frames 0–5 = 1; frame 6 = 0; frame 7 = config_bit; frames 8–11 = id[7:4] (config=0) or data[15:12] (config=1); frame 12 = 0; frames 13–16 = id[3:0]; frame 17 = 0.
  - bit2: frames 0–5 = CRC6 MSB first; frames 6–17 = data[11:0] MSB first.
- fifo_rd is never asserted while fifo_empty=1.

## Timing
- Reset values: fifo_rd=0, frame_valid=0, frame_data=0, frame_status=0, msg_done=0, underflow=0. State=IDLE, frame_idx=0, last-data=0.
- Latency from enable rising to first frame_valid is 2 cycles: IDLE→LOAD, then LOAD→SEND.
- Back-to-back throughput is at most one frame per 2 cycles, because there is one LOAD cycle between acceptances.
- fifo_rd and underflow are asserted in the LOAD cycle.
- msg_done is asserted in the cycle after last-frame acceptance.
- Asynchronous reset mid-message drops the message. The next message after reset starts at frame 0.

## Configuration
- SENT_SERIAL_CRC_EN defined:
  - CRC4 uses poly x^4+x^3+x^2+1, seed 4'b0101, computed over the 3 id/data nibbles.
  - CRC6 uses poly x^6+x^4+x^3+1, seed 6'b010101, computed over the 24 message bits as 4 six-bit words.
  - Both are computed in IDLE/at message sample, complete before frame 0 leaves LOAD.
- SENT_SERIAL_CRC_EN undefined: CRC bit positions transmit 0 and no CRC logic is built.

## Structure
- Package sent_pkg holds:
  - SHORT_FRAMES=16, ENH_FRAMES=18;
  - CRC polynomials and seeds;
  - the state enum (IDLE/LOAD/SEND).
- One sub-module, sent_serial_crc: a combinational CRC4/CRC6 calculator selected by channel_format, instantiated only under SENT_SERIAL_CRC_EN.

## Test plan
- Reset with enable=1 held: all outputs 0. First frame_valid appears exactly 2 cycles after PRESETn release.
- FIFO preloaded with 12'h001..12'h010, frame_ready tied 1, channel_format=0, id=8'h05, data_bit_field=16'h0001: 16 frames with frame_data 001..010. bit3 is 1 only on frame 0. bit2 frames 0–11 = 0101_00000001. One msg_done pulse.
- channel_format=1, config_bit=0, id=8'h55, data_bit_field=16'h0001: 18 frames.
  - bit3 frames 6–17 = 0,0,0101,0,0101,0.
  - bit2 frames 6–17 = 000000000001.
- FIFO holding 2 words, 5 frames requested: frames 3–5 repeat the second word. underflow pulses 3 times; fifo_rd pulses only twice.
- frame_ready held low for 10 cycles in SEND: frame_valid/data/status stay stable and no fifo_rd occurs.
- enable dropped at frame 4: the message completes to frame 15, msg_done pulses, and the block returns to IDLE with frame_valid=0.
